// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int P2_DEF     = 2;
  localparam int P4_DEF     = 4;
  localparam int P10_DEF    = 10;
  localparam int LOCK_N_DEF = 4;

  // Period counter must hold values up to 2*P (the timeout point).
  function automatic int cnt_width(input int p);
    return $clog2(2 * p + 1);
  endfunction

endpackage

// File: rtl/div_chan_mon.sv
// One monitored channel: input capture, rising-edge strobe, period
// counter with timeout, and a lock/error state machine.
module div_chan_mon
  import clk_div_mon_pkg::*;
#(
  parameter int P      = P2_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  input  logic err_clr,
  output logic rise,
  output logic locked,
  output logic err
);

  localparam int            CW        = cnt_width(P);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_PER   = CW'(P);
  localparam logic [CW-1:0] CNT_MAX   = CW'(2 * P);
  localparam logic [CW-1:0] CNT_PRE   = CW'(2 * P - 1);
  localparam logic [3:0]    GOOD_LOCK = 4'(LOCK_N);

  logic          s0;
  logic          s1;
  logic          e;
  logic [CW-1:0] cnt;
  logic [3:0]    good;
  logic [3:0]    good_inc;
  logic          period_ok;
  logic          timeout;
  logic          active;
  logic          err_set;
  mon_state_t    state;

  assign e         = s0 & ~s1;
  assign period_ok = (cnt == CNT_PER);
  // The edge on which cnt would step onto 2*P with no input edge.
  assign timeout   = ~e & (cnt == CNT_PRE);
  assign active    = (state == MEASURE) | (state == LOCKED);
  assign err_set   = active & ((e & ~period_ok) | timeout);
  assign good_inc  = good + 4'd1;

  // Two-flop capture of the divided clock and registered edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s0   <= div_in;
      s1   <= s0;
      rise <= e;
    end
  end

  // Cycles since the last edge; restarts at 1 and saturates at 2*P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (e) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Lock state machine with registered lock flag and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      good   <= 4'd0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      // A new error outranks a simultaneous clear.
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (e) begin
            state <= MEASURE;
            good  <= 4'd0;
          end
        end
        MEASURE: begin
          if (e) begin
            if (period_ok) begin
              good <= good_inc;
              if (good_inc == GOOD_LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good <= 4'd0;
            end
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (e) begin
            if (!period_ok) begin
              state  <= MEASURE;
              locked <= 1'b0;
              good   <= 4'd0;
            end
          end else if (timeout) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          good   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Health monitor for the /2, /4 and /10 divider outputs: three
// independent channel monitors with their outputs packed into buses.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int LOCK_N = LOCK_N_DEF,
  parameter int P2     = P2_DEF,
  parameter int P4     = P4_DEF,
  parameter int P10    = P10_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div2_in,
  input  logic       div4_in,
  input  logic       div10_in,
  input  logic       err_clr,
  output logic [2:0] rise,
  output logic [2:0] locked,
  output logic [2:0] err
);

  div_chan_mon #(.P(P2), .LOCK_N(LOCK_N)) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div2_in),
    .err_clr (err_clr),
    .rise    (rise[0]),
    .locked  (locked[0]),
    .err     (err[0])
  );

  div_chan_mon #(.P(P4), .LOCK_N(LOCK_N)) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div4_in),
    .err_clr (err_clr),
    .rise    (rise[1]),
    .locked  (locked[1]),
    .err     (err[1])
  );

  div_chan_mon #(.P(P10), .LOCK_N(LOCK_N)) u_ch2 (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div10_in),
    .err_clr (err_clr),
    .rise    (rise[2]),
    .locked  (locked[2]),
    .err     (err[2])
  );

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with hand-computed edge timing.
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       div2_in;
  logic       div4_in;
  logic       div10_in;
  logic       err_clr;
  logic [2:0] rise;
  logic [2:0] locked;
  logic [2:0] err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ph0, ph1, ph2;
  int hold0, hold1;
  logic [2:0] en;
  int rc0, rc1, rc2;

  clk_div_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .div2_in  (div2_in),
    .div4_in  (div4_in),
    .div10_in (div10_in),
    .err_clr  (err_clr),
    .rise     (rise),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    div2_in  = en[0] && (ph0 < 1);
    div4_in  = en[1] && (ph1 < 2);
    div10_in = en[2] && (ph2 < 5);
  endtask

  // Restart all three ideal waveforms; inputs go high before the next edge.
  task automatic start_waves();
    ph0 = 0; ph1 = 0; ph2 = 0;
    hold0 = 0; hold1 = 0;
    en  = 3'b111;
    cyc = 0;
    drive_inputs();
  endtask

  // One clock: count rise strobes, then advance the waveforms.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    rc0 += int'(rise[0]);
    rc1 += int'(rise[1]);
    rc2 += int'(rise[2]);
    if (en[0]) begin
      if (hold0 > 0) hold0--;
      else ph0 = (ph0 + 1) % 2;
    end
    if (en[1]) begin
      if (hold1 > 0) hold1--;
      else ph1 = (ph1 + 1) % 4;
    end
    if (en[2]) ph2 = (ph2 + 1) % 10;
    drive_inputs();
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  // First rise after edge 2; locks after edges 10, 18 and 42.
  task automatic lock_sequence(input string pfx);
    tick_to(2);
    check({pfx, "_rise_first"}, 32'(rise), 32'h7);
    tick_to(3);
    check({pfx, "_rise_gap"}, 32'(rise), 32'h0);
    tick_to(9);
    check({pfx, "_lock_c9"}, 32'(locked), 32'h0);
    tick_to(10);
    check({pfx, "_lock_c10"}, 32'(locked), 32'h1);
    tick_to(17);
    check({pfx, "_lock_c17"}, 32'(locked), 32'h1);
    tick_to(18);
    check({pfx, "_lock_c18"}, 32'(locked), 32'h3);
    tick_to(41);
    check({pfx, "_lock_c41"}, 32'(locked), 32'h3);
    tick_to(42);
    check({pfx, "_lock_c42"}, 32'(locked), 32'h7);
    check({pfx, "_err_c42"}, 32'(err), 32'h0);
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    div2_in = 1'b0; div4_in = 1'b0; div10_in = 1'b0;
    en = 3'b000; ph0 = 0; ph1 = 0; ph2 = 0; hold0 = 0; hold1 = 0;
    rc0 = 0; rc1 = 0; rc2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Ideal waveforms.
    start_waves();
    lock_sequence("s1");
    rc0 = 0; rc1 = 0; rc2 = 0;
    tick_to(82);
    check("s1_rise_cnt0", 32'(rc0), 32'd20);
    check("s1_rise_cnt1", 32'(rc1), 32'd10);
    check("s1_rise_cnt2", 32'(rc2), 32'd4);
    check("s1_locked_steady", 32'(locked), 32'h7);
    check("s1_err_steady", 32'(err), 32'h0);

    // Channel 2 stall after its edge at 82; timeout lands on edge 101.
    en[2] = 1'b0;
    drive_inputs();
    tick_to(100);
    check("s2_err_before", 32'(err), 32'h0);
    check("s2_lock_before", 32'(locked), 32'h7);
    tick_to(101);
    check("s2_err_timeout", 32'(err), 32'h4);
    check("s2_lock_timeout", 32'(locked), 32'h3);
    tick_to(110);
    en[2] = 1'b1; ph2 = 0;
    drive_inputs();
    tick_to(151);
    check("s2_relock_before", 32'(locked), 32'h3);
    tick_to(152);
    check("s2_relock", 32'(locked), 32'h7);
    check("s2_err_sticky", 32'(err), 32'h4);

    // Channel 1: stretch high phase by 2 -> 6-cycle period ending at 160.
    hold1 = 2;
    tick_to(159);
    check("s3_err_before", 32'(err), 32'h4);
    check("s3_lock_before", 32'(locked), 32'h7);
    tick_to(160);
    check("s3_err_period", 32'(err), 32'h6);
    check("s3_lock_drop", 32'(locked), 32'h5);
    tick_to(175);
    check("s3_relock_before", 32'(locked), 32'h5);
    tick_to(176);
    check("s3_relock", 32'(locked), 32'h7);

    // Channel 0: 3-cycle period detected at edge 181 while err_clr is high.
    hold0 = 1;
    tick_to(180);
    check("s4_err_before", 32'(err), 32'h6);
    check("s4_lock_before", 32'(locked), 32'h7);
    err_clr = 1'b1;
    tick_to(181);
    err_clr = 1'b0;
    check("s4_err_race", 32'(err), 32'h1);
    check("s4_lock_drop", 32'(locked), 32'h6);
    tick_to(188);
    check("s4_relock_before", 32'(locked), 32'h6);
    tick_to(189);
    check("s4_relock", 32'(locked), 32'h7);
    tick_to(190);
    err_clr = 1'b1;
    tick_to(191);
    err_clr = 1'b0;
    check("s4_err_cleared", 32'(err), 32'h0);
    check("s4_lock_kept", 32'(locked), 32'h7);

    // Mid-lock reset pulse shorter than a cycle, between clock edges.
    tick_to(200);
    check("s5_pre_locked", 32'(locked), 32'h7);
    rst = 1'b1;
    #2;
    check("s5_async_rise", 32'(rise), 32'h0);
    check("s5_async_locked", 32'(locked), 32'h0);
    check("s5_async_err", 32'(err), 32'h0);
    #1;
    rst = 1'b0;
    start_waves();
    lock_sequence("s5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
